fft_spectrum_sink: RTL

//  Receiving end of the FFT core's AXI4-Stream output; consumer of o_axi4s_data_* results.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_mag_approx.sv | 91 +++++++++
 rtl/fft_spectrum_sink.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants, sink state encoding and saturating absolute value for the FFT output path.
package fft_pkg;

  localparam int N_PTS = 256;
  localparam int IDX_W = 8;
  localparam int MAG_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DROP    = 2'd2
  } sink_state_e;

  // |x| for a signed 16-bit value; the one unrepresentable case (-32768) clamps to 32767.
  function automatic logic [15:0] sat_abs16(input logic [15:0] x);
    logic [15:0] r;
    if (x == 16'h8000) begin
      r = 16'h7fff;
    end else if (x[15]) begin
      r = ~x + 16'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_mag_approx.sv
// Two-stage alpha-max-beta-min magnitude estimate (max + min/2) with valid/index/last sideband.
module fft_mag_approx
  import fft_pkg::*;
#(
  parameter int MAG_WIDTH = MAG_W
) (
  input  logic                 fft_clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [31:0]          in_data,
  input  logic [IDX_W-1:0]     in_idx,
  input  logic                 in_last,
  output logic                 out_valid,
  output logic [IDX_W-1:0]     out_idx,
  output logic [MAG_WIDTH-1:0] out_mag,
  output logic                 out_last
);

  localparam logic [16:0] SAT_MAX = 17'((1 << MAG_WIDTH) - 1);

  logic                 s1_valid_r;
  logic                 s1_last_r;
  logic [IDX_W-1:0]     s1_idx_r;
  logic [15:0]          s1_are_r;
  logic [15:0]          s1_aim_r;
  logic [15:0]          max_s;
  logic [15:0]          min_s;
  logic [16:0]          sum_s;
  logic [MAG_WIDTH-1:0] mag_s;
  logic                 s2_valid_r;
  logic                 s2_last_r;
  logic [IDX_W-1:0]     s2_idx_r;
  logic [MAG_WIDTH-1:0] s2_mag_r;

  // Stage 1: register saturated absolute values of both components
  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_idx_r   <= {IDX_W{1'b0}};
      s1_are_r   <= 16'd0;
      s1_aim_r   <= 16'd0;
    end else begin
      s1_valid_r <= in_valid;
      s1_last_r  <= in_valid & in_last;
      s1_idx_r   <= in_idx;
      s1_are_r   <= sat_abs16(in_data[15:0]);
      s1_aim_r   <= sat_abs16(in_data[31:16]);
    end
  end

  // Stage 2 arithmetic: max + (min>>1) in 17 bits, clamped to the stored width
  always_comb begin
    max_s = s1_aim_r;
    min_s = s1_are_r;
    if (s1_are_r >= s1_aim_r) begin
      max_s = s1_are_r;
      min_s = s1_aim_r;
    end else begin
      max_s = s1_aim_r;
      min_s = s1_are_r;
    end
    sum_s = {1'b0, max_s} + ({1'b0, min_s} >> 1);
    if (sum_s > SAT_MAX) begin
      mag_s = {MAG_WIDTH{1'b1}};
    end else begin
      mag_s = sum_s[MAG_WIDTH-1:0];
    end
  end

  // Stage 2 registers feeding the RAM write port
  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_idx_r   <= {IDX_W{1'b0}};
      s2_mag_r   <= {MAG_WIDTH{1'b0}};
    end else begin
      s2_valid_r <= s1_valid_r;
      s2_last_r  <= s1_valid_r & s1_last_r;
      s2_idx_r   <= s1_idx_r;
      s2_mag_r   <= mag_s;
    end
  end

  assign out_valid = s2_valid_r;
  assign out_last  = s2_last_r;
  assign out_idx   = s2_idx_r;
  assign out_mag   = s2_mag_r;

endmodule

// File: rtl/fft_spectrum_sink.sv
// AXI4-Stream sink turning FFT beats into magnitudes in a ping-pong spectrum buffer.
// Optional feature: define PEAK_DETECT_EN to add peak_bin/peak_mag outputs.
module fft_spectrum_sink
  import fft_pkg::*;
#(
  parameter int MAG_WIDTH = MAG_W
) (
  input  logic                 fft_clk,
  input  logic                 rst_n,
  input  logic                 s_tvalid,
  input  logic [31:0]          s_tdata,
  input  logic                 s_tlast,
  input  logic [IDX_W-1:0]     s_tuser,
  output logic                 s_tready,
  input  logic                 freeze,
  input  logic [IDX_W-1:0]     rd_addr,
  output logic [MAG_WIDTH-1:0] rd_data,
  output logic                 rd_bank,
  output logic                 frame_done,
  output logic                 frame_err
`ifdef PEAK_DETECT_EN
  ,
  output logic [IDX_W-1:0]     peak_bin,
  output logic [MAG_WIDTH-1:0] peak_mag
`endif
);

  localparam logic [1:0]       ST_IDLE    = IDLE;
  localparam logic [1:0]       ST_CAPTURE = CAPTURE;
  localparam logic [1:0]       ST_DROP    = DROP;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_PTS - 1);

  logic                 ready_r;
  logic [1:0]           state_r;
  logic [IDX_W-1:0]     cnt_r;
  logic                 err_r;
  logic                 accept_s;
  logic [1:0]           state_nxt_s;
  logic [IDX_W-1:0]     cnt_nxt_s;
  logic                 err_s;
  logic                 commit_s;
  logic                 wr_valid_s;
  logic [IDX_W-1:0]     wr_idx_s;
  logic [MAG_WIDTH-1:0] wr_mag_s;
  logic                 wr_commit_s;
  logic                 wr_bank_s;
  logic                 wr_bank_r;
  logic                 rd_bank_r;
  logic                 commit_pend_r;
  logic                 done_r;
  logic [MAG_WIDTH-1:0] rd_data_r;
  logic [MAG_WIDTH-1:0] ram_r [0:2*N_PTS-1];

  assign accept_s = s_tvalid & ready_r;

  // Frame framing checks: index sequence, tlast position and frame length
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    err_s       = 1'b0;
    commit_s    = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if ((s_tuser == {IDX_W{1'b0}}) && !s_tlast) begin
            state_nxt_s = ST_CAPTURE;
            cnt_nxt_s   = IDX_W'(1);
          end else begin
            err_s       = 1'b1;
            state_nxt_s = s_tlast ? ST_IDLE : ST_DROP;
          end
        end
        ST_CAPTURE: begin
          if (s_tuser != cnt_r) begin
            err_s       = 1'b1;
            state_nxt_s = s_tlast ? ST_IDLE : ST_DROP;
          end else if (cnt_r == LAST_IDX) begin
            if (s_tlast) begin
              commit_s    = 1'b1;
              state_nxt_s = ST_IDLE;
            end else begin
              err_s       = 1'b1;
              state_nxt_s = ST_DROP;
            end
          end else if (s_tlast) begin
            err_s       = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            cnt_nxt_s = cnt_r + IDX_W'(1);
          end
        end
        ST_DROP: begin
          if (s_tlast) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DROP;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state, bin counter, ready and error pulse
  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {IDX_W{1'b0}};
      ready_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ready_r <= 1'b1;
      err_r   <= err_s;
    end
  end

  fft_mag_approx #(
    .MAG_WIDTH (MAG_WIDTH)
  ) u_mag (
    .fft_clk   (fft_clk),
    .rst_n     (rst_n),
    .in_valid  (accept_s),
    .in_data   (s_tdata),
    .in_idx    (s_tuser),
    .in_last   (commit_s),
    .out_valid (wr_valid_s),
    .out_idx   (wr_idx_s),
    .out_mag   (wr_mag_s),
    .out_last  (wr_commit_s)
  );

  // A beat of the next frame can land on the swap edge; it must go to the new write bank
  assign wr_bank_s = (commit_pend_r & ~freeze) ? ~wr_bank_r : wr_bank_r;

  // Spectrum RAM write port; bank bit is the address MSB
  always_ff @(posedge fft_clk) begin
    if (wr_valid_s) begin
      ram_r[{wr_bank_s, wr_idx_s}] <= wr_mag_s;
    end
  end

  // Registered readout from the displayed bank
  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      rd_data_r <= {MAG_WIDTH{1'b0}};
    end else begin
      rd_data_r <= ram_r[{rd_bank_r, rd_addr}];
    end
  end

  // Commit: pulse frame_done one cycle after the last write and swap banks unless frozen
  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      commit_pend_r <= 1'b0;
      done_r        <= 1'b0;
      wr_bank_r     <= 1'b1;
      rd_bank_r     <= 1'b0;
    end else begin
      commit_pend_r <= wr_valid_s & wr_commit_s;
      done_r        <= commit_pend_r;
      if (commit_pend_r && !freeze) begin
        rd_bank_r <= wr_bank_r;
        wr_bank_r <= ~wr_bank_r;
      end
    end
  end

`ifdef PEAK_DETECT_EN
  logic [IDX_W-1:0]     run_bin_r;
  logic [MAG_WIDTH-1:0] run_mag_r;
  logic [IDX_W-1:0]     peak_bin_r;
  logic [MAG_WIDTH-1:0] peak_mag_r;

  // Running strict maximum over bins 1..N_PTS-1, restarted by each bin 0 write
  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      run_bin_r <= {IDX_W{1'b0}};
      run_mag_r <= {MAG_WIDTH{1'b0}};
    end else if (wr_valid_s) begin
      if (wr_idx_s == {IDX_W{1'b0}}) begin
        run_bin_r <= {IDX_W{1'b0}};
        run_mag_r <= {MAG_WIDTH{1'b0}};
      end else if (wr_mag_s > run_mag_r) begin
        run_bin_r <= wr_idx_s;
        run_mag_r <= wr_mag_s;
      end
    end
  end

  // Published peak follows the bank swap
  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      peak_bin_r <= {IDX_W{1'b0}};
      peak_mag_r <= {MAG_WIDTH{1'b0}};
    end else if (commit_pend_r && !freeze) begin
      peak_bin_r <= run_bin_r;
      peak_mag_r <= run_mag_r;
    end
  end

  assign peak_bin = peak_bin_r;
  assign peak_mag = peak_mag_r;
`endif

  assign s_tready   = ready_r;
  assign rd_data    = rd_data_r;
  assign rd_bank    = rd_bank_r;
  assign frame_done = done_r;
  assign frame_err  = err_r;

endmodule
